dcache_wb_param: RTL and testbench
==================================

Name: dcache_wb_param

Overview:
- Parametrised write-back data cache for the MEM stage of the 5-stage MIPS pipeline.
- Replaces the fixed direct-mapped, delay-modelled cache with a configurable 1- or 2-way set-associative cache.
- Adds valid bits and an explicit miss FSM with a handshaked, word-per-beat backing-memory port, so the CPU sees `stall_me` for exactly the real miss duration.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width; the cache serves one word per CPU access.
- LINE_WORDS, 16, words per line; power of 2, ≥2.
- SETS, 512, number of sets; power of 2, ≥2.
- WAYS, 1, associativity; legal values 1 or 2 (2 uses 1 LRU bit per set).

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- addr  in  ADDR_W  CPU byte address; bits [1:0] ignored
- rmem  in  1  CPU read request
- wmem  in  1  CPU write request; wins over rmem if both high
- data_in  in  DATA_W  CPU write data
- data_out  out  DATA_W  CPU read data
- stall_me  out  1  hold the pipeline
- mem_req  out  1  backing-memory beat request
- mem_we  out  1  1 = write beat, 0 = read beat
- mem_addr  out  ADDR_W  word-aligned beat address
- mem_wdata  out  DATA_W  write-beat data
- mem_rdata  in  DATA_W  read-beat data, valid with mem_ack
- mem_ack  in  1  beat completes on a rising edge with mem_req && mem_ack
- hit_cnt  out  32  performance counter (see Optional Feature)
- miss_cnt  out  32  performance counter (see Optional Feature)

Behaviour:
- Address split: offs = addr[log2(LINE_WORDS)+1:2]; index = next log2(SETS) bits; tag = remaining upper bits.
- Hit = access (rmem|wmem) && some way at index has valid && tag match.
- Reset (async, resetn=0): all valid, dirty and LRU bits cleared; FSM=IDLE; stall_me=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_out=0, counters=0. Line data is not reset.
- Reset mid-miss abandons the transaction: mem_req drops immediately and dirty data is lost.
- FSM states:
  - IDLE:
    - Read hit: data_out = hit word combinationally, stall_me=0, zero latency.
    - Write hit: word written at the edge, line marked dirty.
    - Hit (2-way): LRU set to point at the other way.
    - Miss: stall_me=1 combinationally in the same cycle; victim latched (1-way: the only way; 2-way: first invalid way, else the LRU way).
    - Miss transitions: dirty valid victim → WB; otherwise → FILL.
    - No access: data_out holds its last value.
  - WB:
    - mem_req=1, mem_we=1; mem_addr = {victim tag, index, beat, 2'b00}; mem_wdata = victim word[beat].
    - beat advances 0..LINE_WORDS-1 on each ack; after the last ack → FILL with beat=0.
  - FILL:
    - mem_req=1, mem_we=0; mem_addr = {new tag, index, beat, 2'b00}.
    - mem_rdata is written into victim word[beat] on each ack; after the last ack → DONE.
    - mem_req falls in the cycle after the last ack.
  - DONE (1 cycle):
    - Tag written, valid=1; dirty = wmem.
    - Pending write merged at this edge; LRU updated.
    - stall_me=0; data_out = requested word (the write data on writes).
    - Next state IDLE.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata are stable while mem_req && !mem_ack.
  - mem_ack is ignored when mem_req=0.
  - The next beat may issue in the cycle after an ack.
- Miss latency with 0-wait memory: clean miss = LINE_WORDS+1 stall cycles; dirty miss = 2*LINE_WORDS+1 stall cycles.
- The CPU must hold addr, rmem, wmem and data_in stable while stall_me=1; behaviour is undefined otherwise.
- Index wrap: the highest set index aliases nothing. Sets are 0..SETS-1 exactly; there is no extra entry.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- Defined:
  - hit_cnt increments once per IDLE hit cycle.
  - miss_cnt increments once per IDLE→WB/FILL transition.
  - Both counters wrap at 2^32 and are cleared by reset.
- Undefined: hit_cnt and miss_cnt tied to 0 and no counter flops are synthesised.

Test Plan:
(Params for the bench: LINE_WORDS=4, SETS=4, WAYS=2, memory model with mem[i]=i*4 at word address i.)
- Reset, then read addr 0x40: stall 5 cycles (0 wait), 4 read beats at 0x40,0x44,0x48,0x4C → data_out=0x40 in DONE; re-read 0x44 → 0x44, no stall, hit_cnt=1, miss_cnt=1.
- Write 0xDEADBEEF to 0x48 (hit): no stall. Then miss set 0 twice more at 0x140 and 0x240 → 0x240 evicts LRU dirty line 0x40 first: 4 write beats with word 2 = 0xDEADBEEF, then 4 fills.
- Write miss to 0x80 with data 0x12345678: stall, fill, DONE merges the write; read 0x80 → 0x12345678 and the line is dirty.
- Memory with 3-wait ack: clean miss stalls 4*4+1=17 cycles; mem_addr is stable across each wait.
- Assert resetn low mid-FILL (beat 2): mem_req=0 and stall_me=0 immediately; the next read to the same addr misses again.
- rmem=wmem=1 to a hit address with data 0x5 → treated as a write; the following read returns 0x5.

Source files
------------

// File: rtl/dcache_wb_param.sv
// Parametrised 1/2-way write-back data cache with a miss FSM and a handshaked word-per-beat memory port.
// Optional hit/miss performance counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache_wb_param #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int SETS       = 512,
  parameter int WAYS       = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rmem,
  input  logic              wmem,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              stall_me,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFFS_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFFS_W - 2;
  localparam logic [OFFS_W-1:0] LAST_BEAT = OFFS_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  logic [DATA_W-1:0] data_ram [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0]  tag_ram  [WAYS][SETS];

  logic [WAYS-1:0][SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0]           lru_q, lru_d;
  state_t                    state_q, state_d;
  logic [OFFS_W-1:0]         beat_q, beat_d;
  logic                      victim_q, victim_d;
  logic [DATA_W-1:0]         data_out_q, data_out_d;

  logic [OFFS_W-1:0] offs;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              access, hit, hit_way, victim_sel;
  logic              hit_evt, miss_evt;
  logic              ram_we, ram_way, tag_we;
  logic [OFFS_W-1:0] ram_word;
  logic [DATA_W-1:0] ram_wdata;
  wire               unused_addr_bits = ^addr[1:0];

  assign offs   = addr[OFFS_W+1:2];
  assign idx    = addr[OFFS_W+IDX_W+1:OFFS_W+2];
  assign tag    = addr[ADDR_W-1:OFFS_W+IDX_W+2];
  assign access = rmem | wmem;

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && tag_ram[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
    end
  end

  // Prefer an invalid way; otherwise the LRU bit names the way to evict.
  assign victim_sel = (WAYS == 1)             ? 1'b0 :
                      !valid_q[0][idx]        ? 1'b0 :
                      !valid_q[WAYS-1][idx]   ? 1'b1 : lru_q[idx];

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    victim_d   = victim_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    lru_d      = lru_q;
    stall_me   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ram_we     = 1'b0;
    ram_way    = victim_q;
    ram_word   = offs;
    ram_wdata  = data_in;
    tag_we     = 1'b0;
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && hit) begin
          hit_evt    = 1'b1;
          lru_d[idx] = ~hit_way;
          if (wmem) begin
            ram_we                = 1'b1;
            ram_way               = hit_way;
            dirty_d[hit_way][idx] = 1'b1;
            data_out_d            = data_in;
          end else begin
            data_out_d = data_ram[hit_way][idx][offs];
          end
        end else if (access) begin
          // Gated by resetn so an access held through reset never shows a stall.
          stall_me = resetn;
          miss_evt = 1'b1;
          victim_d = victim_sel;
          beat_d   = '0;
          state_d  = (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]) ? WB : FILL;
        end
      end
      WB: begin
        stall_me  = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_ram[victim_q][idx], idx, beat_q, 2'b00};
        mem_wdata = data_ram[victim_q][idx][beat_q];
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = FILL;
        end
      end
      FILL: begin
        stall_me = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tag, idx, beat_q, 2'b00};
        if (mem_ack) begin
          ram_we    = 1'b1;
          ram_word  = beat_q;
          ram_wdata = mem_rdata;
          beat_d    = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        tag_we                 = 1'b1;
        valid_d[victim_q][idx] = 1'b1;
        dirty_d[victim_q][idx] = wmem;
        lru_d[idx]             = ~victim_q;
        if (wmem) begin
          ram_we     = 1'b1;
          data_out_d = data_in;
        end else begin
          data_out_d = data_ram[victim_q][idx][offs];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out = data_out_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      victim_q   <= 1'b0;
      data_out_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      victim_q   <= victim_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      lru_q      <= lru_d;
    end
  end

  // Line data and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clock) begin
    if (ram_we) data_ram[ram_way][idx][ram_word] <= ram_wdata;
    if (tag_we) tag_ram[victim_q][idx] <= tag;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, hit_evt};
    miss_cnt_d = miss_cnt_q + {31'd0, miss_evt};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  wire unused_evt = hit_evt ^ miss_evt;
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_wb_param.sv
// Directed bench for dcache_wb_param (LINE_WORDS=4, SETS=4, WAYS=2) with a wait-state memory model.
module tb_dcache_wb_param;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] addr, data_in, data_out, mem_addr, mem_wdata, mem_rdata, hit_cnt, miss_cnt;
  logic        rmem, wmem, stall_me, mem_req, mem_we, mem_ack;

`ifdef DCACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  int          wait_cycles = 0;
  int          wait_cnt = 0;
  logic [31:0] beat_addr;
  bit          addr_unstable = 1'b0;
  logic [31:0] log_addr [$];
  logic        log_we   [$];
  logic [31:0] log_data [$];

  dcache_wb_param #(
    .ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .SETS(4), .WAYS(2)
  ) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .rmem(rmem), .wmem(wmem),
    .data_in(data_in), .data_out(data_out), .stall_me(stall_me),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  // Memory model: ack is raised at the negedge so the beat completes on the following posedge.
  always @(negedge clock) begin
    if (mem_req) begin
      if (wait_cnt == 0) beat_addr = mem_addr;
      else if (mem_addr !== beat_addr) addr_unstable = 1'b1;
      if (wait_cnt >= wait_cycles) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr[11:2]];
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_data.push_back(mem_wdata);
        if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        wait_cnt = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_data.delete();
  endtask

  task automatic do_access(input logic [31:0] a, input logic r, input logic w,
                           input logic [31:0] d, output int stalls, output logic [31:0] dout);
    @(posedge clock); #1;
    addr = a; rmem = r; wmem = w; data_in = d;
    stalls = 0;
    @(negedge clock);
    while (stall_me === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clock);
    end
    dout = data_out;
    @(posedge clock); #1;
    rmem = 1'b0; wmem = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; addr = '0; rmem = 1'b0; wmem = 1'b0; data_in = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (stall_me !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b expected 0", stall_me); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %b expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got %h expected 0", mem_addr); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_data_out got %h expected 0", data_out); end
    checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_counters got %h/%h expected 0/0", hit_cnt, miss_cnt); end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_clean_miss();
    int st;
    logic [31:0] d;
    clear_log();
    do_access(32'h40, 1'b1, 1'b0, 32'h0, st, d);
    checks++; if (st != 5) begin errors++; $display("[TB] FAIL clean_miss_stall got %0d expected 5", st); end
    checks++; if (d !== 32'h40) begin errors++; $display("[TB] FAIL clean_miss_data got %h expected 00000040", d); end
    checks++; if (log_addr.size() != 4) begin errors++; $display("[TB] FAIL clean_miss_beats got %0d expected 4", log_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[i] !== 32'h40 + 32'(4 * i) || log_we[i] !== 1'b0) begin
        errors++; $display("[TB] FAIL clean_miss_beat%0d got %h we=%b expected %h we=0", i, log_addr[i], log_we[i], 32'h40 + 32'(4 * i));
      end
    end
    do_access(32'h44, 1'b1, 1'b0, 32'h0, st, d);
    checks++; if (st != 0) begin errors++; $display("[TB] FAIL hit_stall got %0d expected 0", st); end
    checks++; if (d !== 32'h44) begin errors++; $display("[TB] FAIL hit_data got %h expected 00000044", d); end
    checks++; if (hit_cnt !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("[TB] FAIL hit_cnt got %0d expected %0d", hit_cnt, PERF ? 1 : 0); end
    checks++; if (miss_cnt !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("[TB] FAIL miss_cnt got %0d expected %0d", miss_cnt, PERF ? 1 : 0); end
  endtask

  task automatic test_dirty_evict();
    int st;
    logic [31:0] d, exp_a, exp_d;
    do_access(32'h48, 1'b0, 1'b1, 32'hDEADBEEF, st, d);
    checks++; if (st != 0) begin errors++; $display("[TB] FAIL write_hit_stall got %0d expected 0", st); end
    do_access(32'h140, 1'b1, 1'b0, 32'h0, st, d);
    checks++; if (st != 5 || d !== 32'h140) begin errors++; $display("[TB] FAIL second_way got stall %0d data %h expected 5 00000140", st, d); end
    clear_log();
    do_access(32'h240, 1'b1, 1'b0, 32'h0, st, d);
    checks++; if (st != 9) begin errors++; $display("[TB] FAIL dirty_miss_stall got %0d expected 9", st); end
    checks++; if (d !== 32'h240) begin errors++; $display("[TB] FAIL dirty_miss_data got %h expected 00000240", d); end
    checks++; if (log_addr.size() != 8) begin errors++; $display("[TB] FAIL dirty_miss_beats got %0d expected 8", log_addr.size()); end
    for (int i = 0; i < 8; i++) begin
      exp_a = (i < 4) ? 32'h40 + 32'(4 * i) : 32'h240 + 32'(4 * (i - 4));
      exp_d = (i == 2) ? 32'hDEADBEEF : exp_a;
      checks++;
      if (log_addr[i] !== exp_a || log_we[i] !== (i < 4) || (i < 4 && log_data[i] !== exp_d)) begin
        errors++; $display("[TB] FAIL evict_beat%0d got %h we=%b wd=%h expected %h we=%b wd=%h",
                           i, log_addr[i], log_we[i], log_data[i], exp_a, i < 4, exp_d);
      end
    end
  endtask

  task automatic test_write_miss();
    int st;
    logic [31:0] d;
    do_access(32'h80, 1'b0, 1'b1, 32'h12345678, st, d);
    checks++; if (st != 5 || d !== 32'h12345678) begin errors++; $display("[TB] FAIL write_miss got stall %0d data %h expected 5 12345678", st, d); end
    do_access(32'h80, 1'b1, 1'b0, 32'h0, st, d);
    checks++; if (st != 0 || d !== 32'h12345678) begin errors++; $display("[TB] FAIL write_miss_readback got stall %0d data %h expected 0 12345678", st, d); end
    do_access(32'h340, 1'b1, 1'b0, 32'h0, st, d);
    checks++; if (st != 5 || d !== 32'h340) begin errors++; $display("[TB] FAIL clean_victim got stall %0d data %h expected 5 00000340", st, d); end
    clear_log();
    do_access(32'h440, 1'b1, 1'b0, 32'h0, st, d);
    checks++; if (st != 9) begin errors++; $display("[TB] FAIL merged_dirty_stall got %0d expected 9", st); end
    checks++;
    if (log_addr[0] !== 32'h80 || log_we[0] !== 1'b1 || log_data[0] !== 32'h12345678) begin
      errors++; $display("[TB] FAIL merged_writeback got %h we=%b wd=%h expected 00000080 we=1 wd=12345678", log_addr[0], log_we[0], log_data[0]);
    end
  endtask

  task automatic test_wait_states();
    int st;
    logic [31:0] d;
    wait_cycles = 3;
    addr_unstable = 1'b0;
    do_access(32'h10, 1'b1, 1'b0, 32'h0, st, d);
    checks++; if (st != 17) begin errors++; $display("[TB] FAIL wait_stall got %0d expected 17", st); end
    checks++; if (d !== 32'h10) begin errors++; $display("[TB] FAIL wait_data got %h expected 00000010", d); end
    checks++; if (addr_unstable !== 1'b0) begin errors++; $display("[TB] FAIL wait_addr_stable got %b expected 0", addr_unstable); end
    wait_cycles = 0;
  endtask

  task automatic test_read_write_both();
    int st;
    logic [31:0] d;
    do_access(32'h14, 1'b1, 1'b1, 32'h5, st, d);
    checks++; if (st != 0) begin errors++; $display("[TB] FAIL rw_both_stall got %0d expected 0", st); end
    do_access(32'h14, 1'b1, 1'b0, 32'h0, st, d);
    checks++; if (d !== 32'h5) begin errors++; $display("[TB] FAIL rw_both_readback got %h expected 00000005", d); end
  endtask

  task automatic test_reset_mid_fill();
    int st;
    int n;
    logic [31:0] d;
    clear_log();
    @(posedge clock); #1;
    addr = 32'h20; rmem = 1'b1; wmem = 1'b0;
    n = 0;
    do begin
      @(negedge clock); #2;
      n++;
    end while (log_addr.size() < 2 && n < 50);
    checks++; if (log_addr.size() != 2) begin errors++; $display("[TB] FAIL mid_fill_reach got %0d beats expected 2", log_addr.size()); end
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_fill_mem_req got %b expected 0", mem_req); end
    checks++; if (stall_me !== 1'b0) begin errors++; $display("[TB] FAIL mid_fill_stall got %b expected 0", stall_me); end
    rmem = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    do_access(32'h20, 1'b1, 1'b0, 32'h0, st, d);
    checks++; if (st != 5 || d !== 32'h20) begin errors++; $display("[TB] FAIL post_reset_miss got stall %0d data %h expected 5 00000020", st, d); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 4);
    mem_ack = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_clean_miss();
    test_dirty_evict();
    test_write_miss();
    test_wait_states();
    test_read_write_both();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
